// File: rtl/qed_pkg.sv
// Shared constants for the QED replay buffer: opcodes, duplicate-mode offsets and the FSM state type.
package qed_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_NOP   = 7'b1111111;

    localparam logic [31:0] QED_NOP = 32'h0000007F;
    localparam logic [4:0]  REG_OFS = 5'd16;

    typedef enum logic [1:0] {
        ST_ORIG = 2'd0,
        ST_DUP  = 2'd1,
        ST_DONE = 2'd2
    } qed_state_e;

    // x0 stays x0 so hardwired-zero semantics are identical in both halves.
    function automatic logic [4:0] remap_reg(input logic [4:0] r);
        return (r == 5'd0) ? r : r + REG_OFS;
    endfunction

endpackage

// File: rtl/qed_inst_remap.sv
// Combinational original->duplicate translation: registers move to the upper half,
// memory accesses move MEM_OFS bytes up.
module qed_inst_remap
    import qed_pkg::*;
#(
    parameter int MEM_OFS = 64
) (
    input  logic [31:0] inst,
    output logic [31:0] remapped
);

    logic [11:0] imm_i;
    logic [11:0] imm_s;

    always_comb begin
        remapped = inst;
        imm_i    = inst[31:20] + 12'(MEM_OFS);
        imm_s    = {inst[31:25], inst[11:7]} + 12'(MEM_OFS);
        case (inst[6:0])
            OP_R: begin
                remapped[11:7]  = remap_reg(inst[11:7]);
                remapped[19:15] = remap_reg(inst[19:15]);
                remapped[24:20] = remap_reg(inst[24:20]);
            end
            OP_I: begin
                remapped[11:7]  = remap_reg(inst[11:7]);
                remapped[19:15] = remap_reg(inst[19:15]);
            end
            OP_LW: begin
                remapped[11:7]  = remap_reg(inst[11:7]);
                remapped[19:15] = remap_reg(inst[19:15]);
                remapped[31:20] = imm_i;
            end
            OP_SW: begin
                remapped[19:15] = remap_reg(inst[19:15]);
                remapped[24:20] = remap_reg(inst[24:20]);
                remapped[31:25] = imm_s[11:5];
                remapped[11:7]  = imm_s[4:0];
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                remapped[11:7]  = remap_reg(inst[11:7]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qed_replay_buffer.sv
// Records accepted original instructions, then replays them remapped as duplicates.
// One fill/drain pass per reset; DONE holds until the next reset.
module qed_replay_buffer
    import qed_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MEM_OFS = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                ifu_instruction,
    input  logic                       ifu_valid,
    input  logic                       stall,
    input  logic                       exec_dup,
    output logic [31:0]                qed_instruction,
    output logic                       qed_valid,
    output logic                       qed_mode,
    output logic [$clog2(DEPTH):0]     orig_count,
    output logic [$clog2(DEPTH):0]     dup_count,
    output logic                       qed_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    qed_state_e      state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [31:0]     dup_inst;
    logic            accept;
    logic            pop;

    assign accept = (state == ST_ORIG) && ifu_valid && !stall;
    assign pop    = (state == ST_DUP) && !stall && (fifo_cnt != '0);

    qed_inst_remap #(.MEM_OFS(MEM_OFS)) u_remap (
        .inst     (mem[rd_ptr]),
        .remapped (dup_inst)
    );

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= ifu_instruction;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_ORIG;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            orig_count      <= '0;
            dup_count       <= '0;
            qed_instruction <= QED_NOP;
            qed_valid       <= 1'b0;
            qed_mode        <= 1'b0;
            qed_ready       <= 1'b0;
        end else begin
            qed_ready <= (state == ST_DONE) && (orig_count == dup_count) && (orig_count != '0);
            case (state)
                ST_ORIG: begin
                    if (accept) begin
                        wr_ptr          <= wr_ptr + 1'b1;
                        fifo_cnt        <= fifo_cnt + 1'b1;
                        qed_instruction <= ifu_instruction;
                        qed_valid       <= 1'b1;
                        qed_mode        <= 1'b0;
                        if (orig_count != CW'(DEPTH)) orig_count <= orig_count + 1'b1;
                    end else if (!stall) begin
                        qed_valid <= 1'b0;
                    end
                    // Filling the last slot forces replay; the same-cycle push lands first.
                    if ((accept && fifo_cnt == CW'(DEPTH - 1)) ||
                        (exec_dup && (fifo_cnt != '0 || accept)))
                        state <= ST_DUP;
                end
                ST_DUP: begin
                    if (pop) begin
                        rd_ptr          <= rd_ptr + 1'b1;
                        fifo_cnt        <= fifo_cnt - 1'b1;
                        qed_instruction <= dup_inst;
                        qed_valid       <= 1'b1;
                        qed_mode        <= 1'b1;
                        if (dup_count != CW'(DEPTH)) dup_count <= dup_count + 1'b1;
                        if (fifo_cnt == CW'(1)) state <= ST_DONE;
                    end
                end
                default: begin
                    qed_instruction <= QED_NOP;
                    qed_valid       <= 1'b0;
                    qed_mode        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Self-checking bench: directed cases plus random episodes against a queue-based reference model.
module tb_qed_replay_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   ifu_instruction;
    logic          ifu_valid, stall, exec_dup;
    logic [31:0]   qed_instruction;
    logic          qed_valid, qed_mode, qed_ready;
    logic [CW-1:0] orig_count, dup_count;

    qed_replay_buffer #(.DEPTH(DEPTH), .MEM_OFS(64)) dut (
        .clk(clk), .rst_n(rst_n), .ifu_instruction(ifu_instruction), .ifu_valid(ifu_valid),
        .stall(stall), .exec_dup(exec_dup), .qed_instruction(qed_instruction),
        .qed_valid(qed_valid), .qed_mode(qed_mode), .orig_count(orig_count),
        .dup_count(dup_count), .qed_ready(qed_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 = recording, 1 = replaying, 2 = finished.
    int          m_phase;
    logic [31:0] m_q[$];
    logic [31:0] m_inst;
    bit          m_valid, m_mode, m_ready;
    int          m_oc, m_dc;

    function automatic logic [31:0] ref_remap(input logic [31:0] x);
        int op, rd, rs1, rs2, imm;
        logic [31:0] y;
        op  = int'(x[6:0]);
        rd  = int'(x[11:7]);
        rs1 = int'(x[19:15]);
        rs2 = int'(x[24:20]);
        if (rd  != 0) rd  = (rd  + 16) % 32;
        if (rs1 != 0) rs1 = (rs1 + 16) % 32;
        if (rs2 != 0) rs2 = (rs2 + 16) % 32;
        y = x;
        case (op)
            'h33: begin y[11:7] = 5'(rd); y[19:15] = 5'(rs1); y[24:20] = 5'(rs2); end
            'h13: begin y[11:7] = 5'(rd); y[19:15] = 5'(rs1); end
            'h03: begin
                imm = (int'(x[31:20]) + 64) % 4096;
                y[11:7] = 5'(rd); y[19:15] = 5'(rs1); y[31:20] = 12'(imm);
            end
            'h23: begin
                imm = (int'(x[31:25]) * 32 + int'(x[11:7]) + 64) % 4096;
                y[19:15] = 5'(rs1); y[24:20] = 5'(rs2);
                y[31:25] = 7'(imm / 32); y[11:7] = 5'(imm % 32);
            end
            'h37, 'h17, 'h6F: y[11:7] = 5'(rd);
            default: ;
        endcase
        return y;
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] ins, input bit st, input bit ed, input bit rs);
        bit nready;
        nready = (m_phase == 2) && (m_oc == m_dc) && (m_oc != 0);
        if (!rs) begin
            m_phase = 0; m_q.delete(); m_inst = 32'h7F;
            m_valid = 0; m_mode = 0; m_oc = 0; m_dc = 0; m_ready = 0;
            return;
        end
        m_ready = nready;
        if (m_phase == 0) begin
            if (v && !st) begin
                m_q.push_back(ins);
                m_inst = ins; m_valid = 1; m_mode = 0; m_oc++;
                if (m_q.size() == DEPTH) m_phase = 1;
            end else if (!st) begin
                m_valid = 0;
            end
            if (ed && m_q.size() != 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!st && m_q.size() != 0) begin
                m_inst = ref_remap(m_q.pop_front());
                m_valid = 1; m_mode = 1; m_dc++;
                if (m_q.size() == 0) m_phase = 2;
            end
        end else begin
            m_inst = 32'h7F; m_valid = 0; m_mode = 1;
        end
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit st, input bit ed, input bit rs);
        ifu_valid = v; ifu_instruction = ins; stall = st; exec_dup = ed; rst_n = rs;
        @(posedge clk);
        model_edge(v, ins, st, ed, rs);
        #1;
        chk("inst",  qed_instruction, m_inst);
        chk("valid", 32'(qed_valid),  32'(m_valid));
        chk("mode",  32'(qed_mode),   32'(m_mode));
        chk("ocnt",  32'(orig_count), 32'(m_oc));
        chk("dcnt",  32'(dup_count),  32'(m_dc));
        chk("ready", 32'(qed_ready),  32'(m_ready));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        logic [6:0]  ops [8];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h7F};
        x = $urandom;
        x[11:7]  = 5'($urandom_range(0, 15));
        x[19:15] = 5'($urandom_range(0, 15));
        x[24:20] = 5'($urandom_range(0, 15));
        if ($urandom_range(0, 9) != 0) x[6:0] = ops[$urandom_range(0, 7)];
        if (x[6:0] == 7'h7F) x = 32'h7F;
        return x;
    endfunction

    initial begin
        rst_n = 0; ifu_valid = 0; ifu_instruction = 0; stall = 0; exec_dup = 0;
        m_phase = 0; m_inst = 32'h7F; m_valid = 0; m_mode = 0; m_oc = 0; m_dc = 0; m_ready = 0;
        #1;

        // Reset values, also asserted while stall is high
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        chk("rst_inst", qed_instruction, 32'h0000007F);

        // ADD x1,x2,x3 replay
        step(1, 32'h003100B3, 0, 0, 1);
        chk("add_orig", qed_instruction, 32'h003100B3);
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 0, 1);
        chk("add_dup", qed_instruction, 32'h013908B3);
        idle(2);
        chk("add_ready", 32'(qed_ready), 32'd1);
        chk("add_cnts", {16'(orig_count), 16'(dup_count)}, {16'd1, 16'd1});

        // LW x5,4(x0) with exec_dup in the accept cycle
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h00402283, 0, 1, 1);
        step(0, 32'h0, 0, 0, 1);
        chk("lw_dup", qed_instruction, 32'h04402A83);
        idle(3);

        // Overfill: fifth instruction ignored, forced replay
        step(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, rand_inst(), 0, 0, 1);
        idle(6);
        chk("full_cnts", {16'(orig_count), 16'(dup_count)}, {16'd4, 16'd4});
        chk("full_ready", 32'(qed_ready), 32'd1);

        // Stall mid-replay
        step(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, rand_inst(), 0, 0, 1);
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, rand_inst(), 1, 1, 1);
        chk("stall_dcnt", 32'(dup_count), 32'd1);
        idle(5);

        // exec_dup with empty FIFO is ignored; reset mid-replay
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 1);
        step(1, 32'h00402283, 0, 0, 1);
        chk("empty_dup_mode", 32'(qed_mode), 32'd0);
        step(1, 32'h003100B3, 0, 1, 1);
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0);
        chk("midrst", {qed_instruction[15:0], 8'(qed_valid), 8'(qed_mode)}, {16'h007F, 8'd0, 8'd0});
        step(1, 32'h00402283, 0, 0, 1);
        chk("post_rst", qed_instruction, 32'h00402283);
        idle(4);

        // Random episodes
        for (int e = 0; e < 30; e++) begin
            step(0, 32'h0, $urandom_range(0, 1), 0, 0);
            for (int c = 0; c < 40; c++)
                step($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/qed_replay_buffer.md
QED_REPLAY_BUFFER -- requirements
Module: qed_replay_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of original instructions held for replay (power of 2, 4..64).
REQ-002 SHALL have parameter MEM_OFS, default 64: byte offset added to LW/SW immediates in duplicates; fixed at 64 for this release.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port ifu_instruction, input, 32: constrained original instruction from fetch.
REQ-006 SHALL have port ifu_valid, input, 1: ifu_instruction is valid this cycle.
REQ-007 SHALL have port stall, input, 1: core cannot accept an instruction this cycle.
REQ-008 SHALL have port exec_dup, input, 1: free (symbolic) request to switch to duplicate mode.
REQ-009 SHALL have port qed_instruction, output, 32: instruction issued to the core.
REQ-010 SHALL have port qed_valid, output, 1: qed_instruction is valid.
REQ-011 SHALL have port qed_mode, output, 1: 0 original, 1 duplicate.
REQ-012 SHALL have ports orig_count and dup_count, output, $clog2(DEPTH)+1 each: originals issued, duplicates issued.
REQ-013 SHALL have port qed_ready, output, 1: consistency check may be evaluated.

Function
REQ-014 SHALL implement states ORIG, DUP, DONE; reset state ORIG.
REQ-015 Accept means ifu_valid and not stall in ORIG; pop means not stall in DUP with FIFO non-empty.
REQ-016 ORIG, accept: push ifu_instruction, register it unmodified onto qed_instruction next cycle with qed_valid=1, increment orig_count.
REQ-017 ORIG, no accept: qed_valid=0 next cycle if not stall; all outputs hold if stall.
REQ-018 ORIG->DUP when exec_dup=1 and (FIFO non-empty or accept this cycle); an instruction accepted in the same cycle is pushed first.
REQ-019 ORIG->DUP forced when a push makes the FIFO full; further ifu_instruction ignored.
REQ-020 exec_dup with empty FIFO and no accept: ignored, stay ORIG.
REQ-021 DUP, pop: register remapped head onto qed_instruction next cycle, qed_valid=1, qed_mode=1, increment dup_count; ifu inputs ignored.
REQ-022 DUP, stall: no pop, outputs hold.
REQ-023 DUP->DONE when the pop empties the FIFO; DONE drives qed_instruction=32'h0000007F (NOP), qed_valid=0, qed_mode=1, until reset.
REQ-024 Remap: nonzero rd/rs1/rs2 fields map r -> r+16; register 0 unchanged; only fields used by the format (R: rd,rs1,rs2; I/LW: rd,rs1; SW: rs1,rs2; LUI/AUIPC/JAL: rd).
REQ-025 Remap: LW imm12 += MEM_OFS; SW {imm7,imm5} += MEM_OFS; NOP and unknown opcodes pass unchanged.
REQ-026 qed_ready=1 iff state DONE and orig_count==dup_count and orig_count!=0; registered.
REQ-027 Counters never wrap; maximum value DEPTH.

Reset
REQ-028 rst_n=0 at a clk edge SHALL set state ORIG, FIFO empty, counts 0, qed_instruction=32'h0000007F, qed_valid=0, qed_mode=0, qed_ready=0, regardless of state or stall.
REQ-029 Reset mid-DUP SHALL discard FIFO contents; first accepted instruction after release issues unmodified.

Structure
REQ-030 qed_pkg SHALL hold opcode constants (R, I, LW, SW, LUI, AUIPC, JAL, NOP), QED_NOP=32'h0000007F, REG_OFS=16, and the state enum.
REQ-031 Remapping SHALL be one combinational sub-module qed_inst_remap; FIFO inline.

Verification
REQ-032 ADD x1,x2,x3 (32'h003100B3) accepted, then exec_dup=1 -> original 32'h003100B3 then duplicate 32'h013908B3, qed_ready=1 with both counts 1.
REQ-033 LW x5,4(x0) (32'h00402283) -> duplicate 32'h04402A83 (rd=21, imm=68, rs1=0).
REQ-034 DEPTH=4, five valid instructions without exec_dup -> fifth ignored, forced DUP, four duplicates, orig_count=dup_count=4.
REQ-035 stall=1 for 3 cycles mid-DUP -> qed_instruction held, dup_count unchanged, no loss or repeat.
REQ-036 exec_dup=1 with empty FIFO -> stays ORIG; rst_n=0 mid-DUP -> all outputs at reset values next cycle.
